// File: rtl/mem_port_arbiter_pkg.sv
//==============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared state encoding, default widths and port IDs for the arbiter.
// Revision: 1.0
//==============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int c_def_dw = 4;
    localparam int c_def_aw = 2;

    localparam logic c_port0 = 1'b0;
    localparam logic c_port1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Two requester command/response channels plus the RAM-side bus.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW = c_def_dw,
    parameter int AW = c_def_aw
) ();

    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_data;
    logic          rsp0_ready;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_data;
    logic          rsp1_ready;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, rsp0_ready,
        input  req1_valid, req1_we, req1_addr, req1_wdata, rsp1_ready,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_we, mem_re, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, rsp0_ready,
        output req1_valid, req1_we, req1_addr, req1_wdata, rsp1_ready,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_we, mem_re, mem_addr, mem_wdata, busy
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
//==============================================================================
// Module  : rr_arb2
// Brief   : Combinational two-request round-robin grant.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  wire logic valid0,
    input  wire logic valid1,
    input  wire logic last_grant,
    output logic      grant_valid,
    output logic      grant_port
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_port  = c_port0;
        // On a tie the port that did not win last time gets the grant.
        if (valid0 && valid1) begin
            grant_port = ~last_grant;
        end else if (valid1) begin
            grant_port = c_port1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module  : mem_port_arbiter
// Brief   : Round-robin two-port command sequencer for the 4x4 vending RAM.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW = c_def_dw,
    parameter int AW = c_def_aw
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mem_port_arbiter_if.slave     bus
);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_grant;
    logic          r_owner;
    logic          r_cmd_we;
    logic [AW-1:0] r_cmd_addr;
    logic [DW-1:0] r_cmd_wdata;
    logic [DW-1:0] r_rsp_data;

    logic          w_gnt_valid;
    logic          w_gnt_port;
    logic          w_accept;
    logic          w_rsp_fire;
    logic          w_issue;

    rr_arb2 u_rr_arb2 (
        .valid0      (bus.req0_valid),
        .valid1      (bus.req1_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_gnt_valid),
        .grant_port  (w_gnt_port)
    );

    // Ready is held low while reset is asserted so no output toggles during reset.
    assign w_accept   = rst_n && (r_state == ST_IDLE) && w_gnt_valid;
    assign w_rsp_fire = (r_state == ST_RESP) &&
                        ((r_owner == c_port1) ? bus.rsp1_ready : bus.rsp0_ready);
    assign w_issue    = (r_state == ST_ISSUE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next_state = ST_ISSUE;
            ST_ISSUE:   w_next_state = r_cmd_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: w_next_state = ST_RESP;
            ST_RESP:    if (w_rsp_fire) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= c_port1;
            r_owner      <= c_port0;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_rsp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt_port;
                r_owner      <= w_gnt_port;
                r_cmd_we     <= (w_gnt_port == c_port1) ? bus.req1_we    : bus.req0_we;
                r_cmd_addr   <= (w_gnt_port == c_port1) ? bus.req1_addr  : bus.req0_addr;
                r_cmd_wdata  <= (w_gnt_port == c_port1) ? bus.req1_wdata : bus.req0_wdata;
            end
            // The RAM read is registered, so its data is valid one cycle after ISSUE.
            if (r_state == ST_RD_WAIT) begin
                r_rsp_data <= bus.mem_rdata;
            end
        end
    end

    assign bus.req0_ready = w_accept && (w_gnt_port == c_port0);
    assign bus.req1_ready = w_accept && (w_gnt_port == c_port1);

    assign bus.mem_we     = w_issue && r_cmd_we;
    assign bus.mem_re     = w_issue && !r_cmd_we;
    assign bus.mem_addr   = w_issue ? r_cmd_addr  : '0;
    assign bus.mem_wdata  = w_issue ? r_cmd_wdata : '0;

    assign bus.rsp0_valid = (r_state == ST_RESP) && (r_owner == c_port0);
    assign bus.rsp1_valid = (r_state == ST_RESP) && (r_owner == c_port1);
    assign bus.rsp0_data  = bus.rsp0_valid ? r_rsp_data : '0;
    assign bus.rsp1_data  = bus.rsp1_valid ? r_rsp_data : '0;

    assign bus.busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed table, corner sequences and random run against a model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int DW = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    mem_port_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM: separate we/re, registered read; pre_* lets the bench seed contents.
    logic [DW-1:0] ram [4];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         port;
        bit         we;
        logic [1:0] addr;
        logic [3:0] wdata;
        logic [3:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        chk("we_re_excl", 32'(bus.mem_we & bus.mem_re), 0);
        chk("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 0);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input bit v, input bit we,
                           input logic [1:0] a, input logic [3:0] d);
        if (p) begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end
    endtask

    task automatic set_rr(input bit p, input bit r);
        if (p) bus.rsp1_ready = r; else bus.rsp0_ready = r;
    endtask

    function automatic logic rdy(input bit p);
        return p ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic rspv(input bit p);
        return p ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction

    function automatic logic [3:0] rspd(input bit p);
        return p ? bus.rsp1_data : bus.rsp0_data;
    endfunction

    task automatic preload(input logic [1:0] a, input logic [3:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        to_next();
        pre_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, 32'(bus.req0_ready), 0);
        chk({tag, "_ready1"}, 32'(bus.req1_ready), 0);
        chk({tag, "_rsp0v"},  32'(bus.rsp0_valid), 0);
        chk({tag, "_rsp1v"},  32'(bus.rsp1_valid), 0);
        chk({tag, "_rsp0d"},  32'(bus.rsp0_data), 0);
        chk({tag, "_rsp1d"},  32'(bus.rsp1_data), 0);
        chk({tag, "_we"},     32'(bus.mem_we), 0);
        chk({tag, "_re"},     32'(bus.mem_re), 0);
        chk({tag, "_addr"},   32'(bus.mem_addr), 0);
        chk({tag, "_wdata"},  32'(bus.mem_wdata), 0);
        chk({tag, "_busy"},   32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
        set_rr(0, 0); set_rr(1, 0);
        to_next(); to_next();
        rst_n = 1'b1;
    endtask

    // One isolated command from the idle state; starts and ends at posedge+1.
    task automatic do_cmd(input vec_t v);
        set_rr(0, 0); set_rr(1, 0);
        set_req(v.port, 1, v.we, v.addr, v.wdata);
        to_neg();
        chk("cmd_ready", 32'(rdy(v.port)), 1);
        chk("cmd_other_ready", 32'(rdy(!v.port)), 0);
        chk("cmd_busy_idle", 32'(bus.busy), 0);
        to_next();
        set_req(v.port, 0, 0, 0, 0);
        to_neg();
        chk("issue_we", 32'(bus.mem_we), 32'(v.we));
        chk("issue_re", 32'(bus.mem_re), 32'(!v.we));
        chk("issue_addr", 32'(bus.mem_addr), 32'(v.addr));
        chk("issue_wdata", 32'(bus.mem_wdata), 32'(v.wdata));
        chk("issue_busy", 32'(bus.busy), 1);
        to_next();
        if (v.we) begin
            to_neg();
            chk("wr_done_busy", 32'(bus.busy), 0);
            chk("wr_done_we", 32'(bus.mem_we), 0);
            to_next();
        end else begin
            to_neg();
            chk("rdwait_rspv", 32'(rspv(v.port)), 0);
            chk("rdwait_re", 32'(bus.mem_re), 0);
            to_next();
            set_rr(v.port, 1);
            to_neg();
            chk("resp_valid", 32'(rspv(v.port)), 1);
            chk("resp_data", 32'(rspd(v.port)), 32'(v.rdata));
            chk("resp_other_valid", 32'(rspv(!v.port)), 0);
            to_next();
            set_rr(v.port, 0);
            to_neg();
            chk("resp_done_valid", 32'(rspv(v.port)), 0);
            chk("resp_done_busy", 32'(bus.busy), 0);
            to_next();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_port [$];
        int g_cyc [$];
        int we_cnt;
        int n0, n1;
        logic [3:0] shadow [4];

        vecs[0] = '{port: 0, we: 1, addr: 2, wdata: 4'hA, rdata: 4'h0};
        vecs[1] = '{port: 0, we: 0, addr: 2, wdata: 4'h5, rdata: 4'hA};
        vecs[2] = '{port: 1, we: 1, addr: 0, wdata: 4'h3, rdata: 4'h0};
        vecs[3] = '{port: 1, we: 0, addr: 0, wdata: 4'h0, rdata: 4'h3};
        vecs[4] = '{port: 0, we: 0, addr: 3, wdata: 4'h0, rdata: 4'hC};
        vecs[5] = '{port: 1, we: 0, addr: 1, wdata: 4'h0, rdata: 4'h2};
        vecs[6] = '{port: 0, we: 1, addr: 3, wdata: 4'h7, rdata: 4'h0};
        vecs[7] = '{port: 1, we: 0, addr: 3, wdata: 4'h0, rdata: 4'h7};

        set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
        set_rr(0, 0); set_rr(1, 0);
        to_next();
        preload(0, 4'h1); preload(1, 4'h2); preload(2, 4'h3); preload(3, 4'hC);
        do_reset();
        to_neg();
        chk_all_zero("reset");
        to_next();

        // Single commands, including write-then-read of the same address.
        for (int i = 0; i < 8; i++) do_cmd(vecs[i]);

        // Simultaneous write (port 0) and read (port 1) to addr 1.
        set_req(0, 1, 1, 1, 4'h5);
        set_req(1, 1, 0, 1, 4'h0);
        to_neg();
        chk("tie_ready0", 32'(bus.req0_ready), 1);
        chk("tie_ready1", 32'(bus.req1_ready), 0);
        to_next();
        set_req(0, 0, 0, 0, 0);
        to_neg();
        chk("tie_wr_we", 32'(bus.mem_we), 1);
        chk("tie_wr_data", 32'(bus.mem_wdata), 5);
        chk("tie_ready1_issue", 32'(bus.req1_ready), 0);
        to_next();
        to_neg();
        chk("tie_ready1_next", 32'(bus.req1_ready), 1);
        to_next();
        set_req(1, 0, 0, 0, 0);
        to_neg(); chk("tie_rd_re", 32'(bus.mem_re), 1);
        to_next();
        to_neg();
        to_next();
        set_rr(1, 1);
        to_neg();
        chk("tie_rsp1_valid", 32'(bus.rsp1_valid), 1);
        chk("tie_rsp1_data", 32'(bus.rsp1_data), 5);
        chk("tie_rsp0_valid", 32'(bus.rsp0_valid), 0);
        to_next();
        set_rr(1, 0);

        // Continuous writes from both ports: grants must alternate.
        we_cnt = 0; n0 = 0; n1 = 0;
        for (int c = 0; c < 20; c++) begin
            set_req(0, n0 < 3, 1, 2'(n0), 4'(n0 + 1));
            set_req(1, n1 < 3, 1, 2'(n1 + 1), 4'(n1 + 8));
            to_neg();
            if (bus.mem_we) we_cnt++;
            if (bus.req0_ready) begin g_port.push_back(0); g_cyc.push_back(c); n0++; end
            if (bus.req1_ready) begin g_port.push_back(1); g_cyc.push_back(c); n1++; end
            to_next();
        end
        set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
        chk("rr_grant_count", 32'(g_port.size()), 6);
        for (int i = 0; i < g_port.size(); i++) chk("rr_grant_order", 32'(g_port[i]), 32'(i % 2));
        for (int i = 1; i < g_cyc.size(); i++) chk("rr_accept_gap", 32'(g_cyc[i] - g_cyc[i-1]), 2);
        chk("rr_we_pulses", 32'(we_cnt), 6);

        // Response back-pressure with a port 0 request waiting.
        preload(3, 4'hC);
        set_req(1, 1, 0, 3, 0);
        set_rr(1, 0);
        to_neg();
        chk("bp_ready1", 32'(bus.req1_ready), 1);
        to_next();
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 1, 0, 4'h9);
        to_neg(); chk("bp_wait_ready0_a", 32'(bus.req0_ready), 0); to_next();
        to_neg(); chk("bp_wait_ready0_b", 32'(bus.req0_ready), 0); to_next();
        for (int k = 0; k < 5; k++) begin
            to_neg();
            chk("bp_rsp1_valid", 32'(bus.rsp1_valid), 1);
            chk("bp_rsp1_data", 32'(bus.rsp1_data), 32'hC);
            chk("bp_rsp0_valid", 32'(bus.rsp0_valid), 0);
            chk("bp_ready0_held", 32'(bus.req0_ready), 0);
            to_next();
        end
        set_rr(1, 1);
        to_neg();
        chk("bp_rsp1_final", 32'(bus.rsp1_valid), 1);
        chk("bp_ready0_resp", 32'(bus.req0_ready), 0);
        to_next();
        set_rr(1, 0);
        to_neg();
        chk("bp_ready0_after", 32'(bus.req0_ready), 1);
        chk("bp_rsp1_gone", 32'(bus.rsp1_valid), 0);
        to_next();
        set_req(0, 0, 0, 0, 0);
        to_neg();
        chk("bp_wr_we", 32'(bus.mem_we), 1);
        chk("bp_wr_addr", 32'(bus.mem_addr), 0);
        chk("bp_wr_data", 32'(bus.mem_wdata), 9);
        to_next();
        to_neg(); to_next();

        // Reset during RD_WAIT of a port 0 read.
        set_req(0, 1, 0, 2, 0);
        set_rr(0, 1);
        to_neg(); chk("rst_accept", 32'(bus.req0_ready), 1); to_next();
        set_req(0, 0, 0, 0, 0);
        to_neg(); chk("rst_issue_re", 32'(bus.mem_re), 1); to_next();
        rst_n = 1'b0;
        to_neg(); chk("rst_rdwait_busy", 32'(bus.busy), 1); to_next();
        rst_n = 1'b1;
        to_neg();
        chk_all_zero("midrst");
        to_next();
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("midrst_no_rsp0", 32'(bus.rsp0_valid), 0);
            chk("midrst_idle", 32'(bus.busy), 0);
            to_next();
        end
        do_cmd('{port: 0, we: 0, addr: 0, wdata: 4'h0, rdata: 4'h9});

        // Random traffic against a transaction-level timing/data model.
        for (int a = 0; a < 4; a++) begin
            shadow[a] = 4'($urandom);
            preload(2'(a), shadow[a]);
        end
        do_reset();
        begin
            int free_at, lg, rsp_from, issue_at, pend_port, exp_gp;
            bit pend, idle, exp_gv, vis, iss_we;
            logic [1:0] iss_addr;
            logic [3:0] iss_wdata, pend_val;
            bit v [2];
            bit rw [2];
            logic [1:0] ra [2];
            logic [3:0] rd [2];
            bit rr [2];
            free_at = 0; lg = 1; pend = 0; pend_port = 0; pend_val = 0;
            rsp_from = 0; issue_at = -10; iss_we = 0; iss_addr = 0; iss_wdata = 0;
            v[0] = 0; v[1] = 0;
            for (int c = 0; c < 800; c++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!v[p]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            v[p] = 1; rw[p] = 1'($urandom_range(0, 1));
                            ra[p] = 2'($urandom); rd[p] = 4'($urandom);
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        v[p] = 0;
                    end
                    rr[p] = ($urandom_range(0, 2) != 0);
                    set_req(1'(p), v[p], rw[p], ra[p], rd[p]);
                    set_rr(1'(p), rr[p]);
                end
                to_neg();
                idle = (c >= free_at) && !pend;
                exp_gv = idle && (v[0] || v[1]);
                exp_gp = (v[0] && v[1]) ? 1 - lg : (v[1] ? 1 : 0);
                chk("rnd_ready0", 32'(bus.req0_ready), 32'(exp_gv && exp_gp == 0));
                chk("rnd_ready1", 32'(bus.req1_ready), 32'(exp_gv && exp_gp == 1));
                chk("rnd_busy", 32'(bus.busy), 32'(!idle));
                if (c == issue_at) begin
                    chk("rnd_issue_we", 32'(bus.mem_we), 32'(iss_we));
                    chk("rnd_issue_re", 32'(bus.mem_re), 32'(!iss_we));
                    chk("rnd_issue_addr", 32'(bus.mem_addr), 32'(iss_addr));
                    chk("rnd_issue_wdata", 32'(bus.mem_wdata), 32'(iss_wdata));
                end else begin
                    chk("rnd_quiet_mem", {bus.mem_we, bus.mem_re, 2'b0, bus.mem_addr, bus.mem_wdata}, 0);
                end
                vis = pend && (c >= rsp_from);
                chk("rnd_rsp0_valid", 32'(bus.rsp0_valid), 32'(vis && pend_port == 0));
                chk("rnd_rsp1_valid", 32'(bus.rsp1_valid), 32'(vis && pend_port == 1));
                if (vis) chk("rnd_rsp_data", 32'(rspd(1'(pend_port))), 32'(pend_val));
                if (exp_gv) begin
                    lg = exp_gp;
                    issue_at = c + 1;
                    iss_we = rw[exp_gp]; iss_addr = ra[exp_gp]; iss_wdata = rd[exp_gp];
                    v[exp_gp] = 0;
                    if (iss_we) begin
                        shadow[iss_addr] = iss_wdata;
                        free_at = c + 2;
                    end else begin
                        pend = 1; pend_port = exp_gp;
                        pend_val = shadow[iss_addr];
                        rsp_from = c + 3;
                    end
                end
                if (vis && rr[pend_port]) begin
                    pend = 0;
                    free_at = c + 1;
                end
                to_next();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
